rr_mux_arbiter: RTL and testbench



---
 rtl/rr_mux_pkg.sv | 11 +
 rtl/rr_mux_arbiter_arb.sv | 39 +++
 rtl/rr_mux_arbiter.sv | 57 +++++
 tb/tb_rr_mux_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg: shared arbitration modes, output-register states and index-width helper
package rr_mux_pkg;
    localparam int MODE_FIXED = 0;
    localparam int MODE_RR = 1;
    typedef enum logic {EMPTY, FULL} out_state_e;
    function automatic int sel_w(input int n);
        for (int w = 1; w < 32; w++)
            if ((1 << w) >= n) return w;
        return 32;
    endfunction
endpackage

// File: rtl/rr_mux_arbiter_arb.sv
// rr_arbiter: one-hot grant over req, fixed priority or round-robin from a rotating pointer
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter int N = 4,
    parameter int MODE = MODE_RR,
    localparam int SELW = sel_w(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic            advance,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] grant_idx
);
    logic [SELW-1:0] ptr_q, ptr_d, j;
    int k;
    always_comb begin
        grant = '0;
        grant_idx = '0;
        k = 0;
        j = '0;
        // scan from lowest to highest priority so the winner is the last one written
        for (int i = N - 1; i >= 0; i--) begin
            k = (MODE == MODE_RR) ? int'(ptr_q) + i : i;
            j = SELW'((k >= N) ? k - N : k);
            if (req[j]) begin
                grant = '0;
                grant[j] = 1'b1;
                grant_idx = j;
            end
        end
        ptr_d = (MODE == MODE_RR && advance) ? ((grant_idx == SELW'(N - 1)) ? '0 : grant_idx + SELW'(1)) : ptr_q;
    end
    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else ptr_q <= ptr_d;
    end
endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: N-channel registered mux with valid/ready handshakes and built-in arbiter
module rr_mux_arbiter
    import rr_mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N = 4,
    parameter int MODE = MODE_RR,
    localparam int SELW = sel_w(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    output logic [SELW-1:0]    out_sel,
    input  logic               out_ready
);
    out_state_e state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d, mux;
    logic [SELW-1:0] sel_q, sel_d, grant_idx;
    logic [N-1:0] grant;
    logic load;
    rr_arbiter #(.N(N), .MODE(MODE)) u_arb (
        .clk(clk),
        .reset(reset),
        .req(in_valid),
        .advance(load),
        .grant(grant),
        .grant_idx(grant_idx)
    );
    always_comb begin
        mux = '0;
        for (int i = 0; i < N; i++) mux = mux | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
        // drain and refill on the same edge keeps throughput at one word per cycle
        load = !reset && (state_q == EMPTY || out_ready) && |in_valid;
        in_ready = load ? grant : '0;
        state_d = load ? FULL : (out_ready ? EMPTY : state_q);
        data_d = load ? mux : data_q;
        sel_d = load ? grant_idx : sel_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            data_q <= '0;
            sel_q <= '0;
        end else begin
            state_q <= state_d;
            data_q <= data_d;
            sel_q <= sel_d;
        end
    end
    assign out_valid = (state_q == FULL);
    assign out_data = data_q;
    assign out_sel = sel_q;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed vector table on N=4 instances plus randomized scoreboard sweep on N=2/N=5
module tb_rr_mux_arbiter;
    logic clk = 0;
    logic reset = 1;
    logic [127:0] in_data = '0;
    logic [3:0] in_valid = '0;
    logic out_ready = 0;
    logic [3:0] ir_rr, ir_fp;
    logic [31:0] od_rr, od_fp;
    logic ov_rr, ov_fp;
    logic [1:0] os_rr, os_fp;
    logic [15:0] n2_d = '0;
    logic [1:0] n2_v = '0, n2_ir;
    logic n2_r = 0, n2_ov;
    logic [7:0] n2_od;
    logic [0:0] n2_os;
    logic [79:0] n5_d = '0;
    logic [4:0] n5_v = '0, n5_ir;
    logic n5_r = 0, n5_ov;
    logic [15:0] n5_od;
    logic [2:0] n5_os;

    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    rr_mux_arbiter #(.WIDTH(32), .N(4), .MODE(1)) u_rr (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(ir_rr),
        .out_data(od_rr), .out_valid(ov_rr), .out_sel(os_rr), .out_ready(out_ready));
    rr_mux_arbiter #(.WIDTH(32), .N(4), .MODE(0)) u_fp (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(ir_fp),
        .out_data(od_fp), .out_valid(ov_fp), .out_sel(os_fp), .out_ready(out_ready));
    rr_mux_arbiter #(.WIDTH(8), .N(2), .MODE(1)) u_n2 (
        .clk(clk), .reset(reset), .in_data(n2_d), .in_valid(n2_v), .in_ready(n2_ir),
        .out_data(n2_od), .out_valid(n2_ov), .out_sel(n2_os), .out_ready(n2_r));
    rr_mux_arbiter #(.WIDTH(16), .N(5), .MODE(1)) u_n5 (
        .clk(clk), .reset(reset), .in_data(n5_d), .in_valid(n5_v), .in_ready(n5_ir),
        .out_data(n5_od), .out_valid(n5_ov), .out_sel(n5_os), .out_ready(n5_r));

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    endtask

    typedef struct {
        bit rst;
        bit fp;
        logic [3:0] vld;
        bit rdy;
        logic [31:0] d2;
        logic [3:0] ir;
        bit ov;
        logic [1:0] sel;
        logic [31:0] dat;
    } vec_t;
    vec_t vt[$];

    function automatic vec_t row(bit rst, bit fp, logic [3:0] vld, bit rdy, logic [31:0] d2,
                                 logic [3:0] ir, bit ov, logic [1:0] sel, logic [31:0] dat);
        vec_t v;
        v.rst = rst; v.fp = fp; v.vld = vld; v.rdy = rdy; v.d2 = d2;
        v.ir = ir; v.ov = ov; v.sel = sel; v.dat = dat;
        return v;
    endfunction

    task automatic check_out(input int i);
        chk("ov", i, vt[i].fp ? ov_fp : ov_rr, vt[i].ov);
        chk("sel", i, vt[i].fp ? os_fp : os_rr, vt[i].sel);
        chk("data", i, vt[i].fp ? od_fp : od_rr, vt[i].dat);
    endtask

    // sweep reference: output register seen as "holding the last accepted word or not"
    int vld[2][5], chan[2][5], taken[2][5], wt[2][5];
    int rdy[2], m_full[2], m_sel[2], m_data[2], m_ptr[2];

    task automatic sweep_out(input int k);
        chk("sw_ov", k, k != 0 ? 32'(n5_ov) : 32'(n2_ov), m_full[k]);
        if (m_full[k] != 0) begin
            chk("sw_data", k, k != 0 ? 32'(n5_od) : 32'(n2_od), m_data[k]);
            chk("sw_sel", k, k != 0 ? 32'(n5_os) : 32'(n2_os), m_sel[k]);
        end
    endtask

    task automatic sweep_produce(input int k);
        int n = (k != 0) ? 5 : 2;
        for (int i = 0; i < n; i++) begin
            if (taken[k][i] != 0) begin
                vld[k][i] = 0;
                taken[k][i] = 0;
            end
            if (vld[k][i] == 0 && $urandom_range(0, 1) == 1) begin
                vld[k][i] = 1;
                chan[k][i] = int'($urandom & ((k != 0) ? 32'hFFFF : 32'hFF));
            end
        end
        rdy[k] = ($urandom_range(0, 3) != 0) ? 1 : 0;
    endtask

    task automatic pack();
        for (int i = 0; i < 2; i++) begin
            n2_v[i] = vld[0][i][0];
            n2_d[i*8 +: 8] = chan[0][i][7:0];
        end
        for (int i = 0; i < 5; i++) begin
            n5_v[i] = vld[1][i][0];
            n5_d[i*16 +: 16] = chan[1][i][15:0];
        end
        n2_r = rdy[0][0];
        n5_r = rdy[1][0];
    endtask

    task automatic sweep_step(input int k);
        int n = (k != 0) ? 5 : 2;
        int g = -1;
        int maxw = 0;
        bit load;
        int ir_act = (k != 0) ? int'(n5_ir) : int'(n2_ir);
        for (int j = 0; j < n; j++) begin
            int c = (m_ptr[k] + j) % n;
            if (g < 0 && vld[k][c] != 0) g = c;
        end
        load = (m_full[k] == 0 || rdy[k] != 0) && g >= 0;
        chk("sw_ir", k, ir_act, load ? (1 << g) : 0);
        if (load) begin
            for (int i = 0; i < n; i++) begin
                wt[k][i] = (i == g || vld[k][i] == 0) ? 0 : wt[k][i] + 1;
                if (wt[k][i] > maxw) maxw = wt[k][i];
            end
            chk("sw_wait_ok", k, 32'(maxw <= n - 1), 1);
            m_full[k] = 1;
            m_sel[k] = g;
            m_data[k] = chan[k][g];
            m_ptr[k] = (g + 1) % n;
            taken[k][g] = 1;
        end else if (rdy[k] != 0) begin
            m_full[k] = 0;
        end
    endtask

    initial begin
        logic [31:0] a2 = 32'hA2;
        logic [31:0] db = 32'hDEADBEEF;
        for (int k = 0; k < 2; k++) begin
            rdy[k] = 0; m_full[k] = 0; m_sel[k] = 0; m_data[k] = 0; m_ptr[k] = 0;
            for (int i = 0; i < 5; i++) begin
                vld[k][i] = 0; chan[k][i] = 0; taken[k][i] = 0; wt[k][i] = 0;
            end
        end
        pack();

        vt.push_back(row(1, 0, 4'hF, 1, a2, 4'h0, 0, 0, 32'h0));
        for (int i = 0; i < 8; i++)
            vt.push_back(row(0, 0, 4'hF, 1, a2, 4'(1 << (i % 4)), 1, 2'(i % 4), 32'hA0 + 32'(i % 4)));
        vt.push_back(row(0, 0, 4'h4, 1, db, 4'h4, 1, 2, db));
        for (int i = 0; i < 5; i++)
            vt.push_back(row(0, 0, 4'hF, 0, db, 4'h0, 1, 2, db));
        vt.push_back(row(0, 0, 4'hF, 1, db, 4'h8, 1, 3, 32'hA3));
        vt.push_back(row(0, 0, 4'h2, 1, a2, 4'h2, 1, 1, 32'hA1));
        vt.push_back(row(0, 0, 4'h1, 1, a2, 4'h1, 1, 0, 32'hA0));
        vt.push_back(row(0, 0, 4'h0, 1, a2, 4'h0, 0, 0, 32'hA0));
        vt.push_back(row(0, 0, 4'h0, 1, a2, 4'h0, 0, 0, 32'hA0));
        vt.push_back(row(0, 0, 4'hF, 1, a2, 4'h2, 1, 1, 32'hA1));
        vt.push_back(row(0, 0, 4'hF, 0, a2, 4'h0, 1, 1, 32'hA1));
        vt.push_back(row(1, 0, 4'hF, 0, a2, 4'h0, 0, 0, 32'h0));
        vt.push_back(row(0, 0, 4'hF, 1, a2, 4'h1, 1, 0, 32'hA0));
        vt.push_back(row(0, 0, 4'hF, 1, a2, 4'h2, 1, 1, 32'hA1));
        vt.push_back(row(1, 0, 4'hF, 1, a2, 4'h0, 0, 0, 32'h0));
        for (int i = 0; i < 4; i++)
            vt.push_back(row(0, 1, 4'hA, 1, a2, 4'h2, 1, 1, 32'hA1));
        vt.push_back(row(0, 1, 4'hF, 1, a2, 4'h1, 1, 0, 32'hA0));

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            if (i > 0) check_out(i - 1);
            reset = vt[i].rst;
            in_valid = vt[i].vld;
            out_ready = vt[i].rdy;
            in_data = {32'hA3, vt[i].d2, 32'hA1, 32'hA0};
            #1;
            chk("ir", i, vt[i].fp ? ir_fp : ir_rr, vt[i].ir);
        end
        @(negedge clk);
        check_out(vt.size() - 1);

        in_valid = '0;
        reset = 1;
        @(negedge clk);
        reset = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) sweep_out(k);
            for (int k = 0; k < 2; k++) sweep_produce(k);
            pack();
            #1;
            for (int k = 0; k < 2; k++) sweep_step(k);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
